instr_sequencer: RTL

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 114 +++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// Instruction fetch/decode sequencer. It paces an external one-hot stage ring through ce.
// The minimum fetch takes 2 cycles, and ce stays low until mem_ack arrives. HALT and ERR hold ce low until clr.
module instr_sequencer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              f_st,
    input  logic              d_st,
    input  logic              e_st,
    input  logic              i_st,
    output logic              ce,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic [3:0]        opcode,
    output logic [3:0]        operand,
    output logic              dec_valid,
    output logic              ld_acc,
    output logic              alu_en,
    output logic              wb_en,
    output logic              halted,
    output logic              err
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;
    localparam logic [1:0] S_ERR   = 2'd3;

    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_JMP = 4'h3;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [2:0]        strb_cnt;

    assign strb_cnt = {2'b00, f_st} + {2'b00, d_st} + {2'b00, e_st} + {2'b00, i_st};

    assign pc       = pc_q;
    assign ir       = ir_q;
    assign mem_addr = pc_q;
    assign opcode   = ir_q[DATA_W-1:DATA_W-4];
    assign operand  = ir_q[3:0];
    assign halted   = (state_q == S_HALT);
    assign err      = (state_q == S_ERR);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        ce        = 1'b0;
        mem_req   = 1'b0;
        dec_valid = 1'b0;
        ld_acc    = 1'b0;
        alu_en    = 1'b0;
        wb_en     = 1'b0;
        case (state_q)
            S_RUN: begin
                // A broken ring (zero or several strobes) overrides every stage action.
                if (strb_cnt != 3'd1) begin
                    state_d = S_ERR;
                end else if (f_st) begin
                    state_d = S_FETCH;
                end else if (d_st) begin
                    ce        = 1'b1;
                    dec_valid = 1'b1;
                end else if (e_st) begin
                    ce = 1'b1;
                    case (opcode)
                        OP_LDI:  ld_acc  = 1'b1;
                        OP_ADD:  alu_en  = 1'b1;
                        OP_JMP:  pc_d    = {pc_q[ADDR_W-1:4], operand};
                        OP_HLT:  state_d = S_HALT;
                        default: ;
                    endcase
                end else begin
                    ce    = 1'b1;
                    wb_en = (opcode == OP_LDI) || (opcode == OP_ADD);
                end
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ce      = 1'b1;
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_RUN;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_RUN;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

endmodule
